wfg_stim_mem_seq: RTL

//  Parametrised stimulus-memory sequencer for the waveform generator. Walks an SRAM from START to END in INC steps,

---
 rtl/wfg_stim_mem_seq_if.sv | 12 +
 rtl/wfg_stim_mem_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wfg_stim_mem_seq_if.sv
// AXI-Stream link carrying stimulus words from the memory sequencer to the waveform core.
interface wfg_stim_mem_seq_if #(
   parameter int DATA_W = 32
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/wfg_stim_mem_seq.sv
// Stimulus-memory sequencer: walks SRAM from start to end in inc steps, prefetches through a
// small FIFO to hide read latency and streams one word per cycle with end-of-pass TLAST.
//
// state   | meaning
// S_IDLE  | disabled, FIFO flushed, waiting for enable
// S_RUN   | issuing SRAM reads whenever a FIFO slot is uncommitted
// S_DRAIN | one-shot pass fully issued, emptying FIFO and in-flight read
// S_DONE  | one-shot pass delivered, done_o held until disable
module wfg_stim_mem_seq #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ctrl_en_q_i,
   input  logic               ctrl_oneshot_q_i,
   input  logic [15:0]        start_val_q_i,
   input  logic [15:0]        end_val_q_i,
   input  logic [7:0]         inc_val_q_i,
   wfg_stim_mem_seq_if.master wfg_axis,
   output logic               done_o,
   output logic               csb1,
   output logic [ADDR_W-1:0]  addr1,
   input  logic [DATA_W-1:0]  dout1
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [15:0]      r_start;
   logic [15:0]      r_end;
   logic [15:0]      r_cur;
   logic [7:0]       r_inc;
   logic             r_oneshot;
   logic             r_infl;
   logic             r_infl_last;

   logic [DATA_W:0]  r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_issue;
   logic             w_push;
   logic             w_pop;
   logic             w_room;
   logic             w_wrap;
   logic             w_start_run;
   logic             w_valid;
   logic [16:0]      w_nxt_addr;
   logic [CNT_W:0]   w_committed;
   logic [DATA_W:0]  w_head;

   // Slots already committed = words buffered plus the read whose data arrives next edge.
   assign w_committed = {1'b0, r_count} + {{CNT_W{1'b0}}, r_infl};
   assign w_room      = (w_committed < DEPTH_C);

   // 17-bit step so an end value near 0xFFFF still terminates the pass.
   assign w_nxt_addr  = {1'b0, r_cur} + {9'd0, r_inc};
   assign w_wrap      = (w_nxt_addr > {1'b0, r_end});

   assign w_valid     = (r_count != '0);
   assign w_pop       = w_valid && wfg_axis.tready;
   assign w_push      = r_infl;
   assign w_start_run = (r_state == S_IDLE) && ctrl_en_q_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ctrl_en_q_i) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_issue = w_room;
            if (w_room && w_wrap && r_oneshot) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave as the final beat is accepted so done_o rises the very next cycle.
            if (!r_infl && (r_count == CNT_W'(w_pop))) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_DONE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (!ctrl_en_q_i) w_state_nxt = S_IDLE;
   end

   assign csb1   = !w_issue;
   assign addr1  = r_cur[ADDR_W-1:0];
   assign done_o = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start   <= '0;
         r_end     <= '0;
         r_inc     <= '0;
         r_oneshot <= 1'b0;
         r_cur     <= '0;
      end else if (w_start_run) begin
         r_start   <= start_val_q_i;
         r_end     <= end_val_q_i;
         r_inc     <= inc_val_q_i;
         r_oneshot <= ctrl_oneshot_q_i;
         r_cur     <= start_val_q_i;
      end else if (w_issue) begin
         r_cur     <= w_wrap ? r_start : w_nxt_addr[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_infl      <= 1'b0;
         r_infl_last <= 1'b0;
      end else begin
         r_infl      <= w_issue && ctrl_en_q_i;
         r_infl_last <= w_wrap;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (!ctrl_en_q_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: outputs are gated by the occupancy count.
   always_ff @(posedge clk) begin
      if (w_push && ctrl_en_q_i) r_fifo[r_wr_ptr] <= {r_infl_last, dout1};
   end

   assign w_head          = r_fifo[r_rd_ptr];
   assign wfg_axis.tvalid = w_valid;
   assign wfg_axis.tdata  = w_valid ? w_head[DATA_W-1:0] : '0;
   assign wfg_axis.tlast  = w_valid && w_head[DATA_W];

endmodule
